fir_out_capture: RTL and testbench

- Downstream stage of the 4-tap floating-point FIR.
- The FIR has no valid signalling, so this block tracks sample validity alongside the FIR's fixed pipeline latency.
- It discards results produced while the tap delay line is still priming, then buffers real results in a small FIFO.
- Results leave through a ready/valid handshake to the consumer; FIFO overflow is reported as a sticky flag.

---
 rtl/fir_out_capture.sv | 140 ++++++++++++++
 tb/tb_fir_out_capture.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_out_capture.sv
// Output capture for the 4-tap FP FIR: tracks sample validity across the FIR latency, drops
// priming results, buffers real ones in a FIFO. Define FIR_CAP_NAN_FLAG_EN to add NaN tagging.
module fir_out_capture #(
  parameter int BITS        = 32,
  parameter int LATENCY     = 20,
  parameter int PRIME_COUNT = 18,
  parameter int DEPTH       = 8,
  parameter int ADDR_W      = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [BITS-1:0]   fir_out,
  output logic [BITS-1:0]   out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              primed
`ifdef FIR_CAP_NAN_FLAG_EN
  ,
  output logic              out_nan,
  output logic              nan_seen
`endif
);

`ifdef FIR_CAP_NAN_FLAG_EN
  localparam int ENTRY_W = BITS + 1;
`else
  localparam int ENTRY_W = BITS;
`endif
  localparam int PCW = (PRIME_COUNT > 1) ? $clog2(PRIME_COUNT) : 1;
  localparam logic [PCW-1:0] PRIME_LAST = PCW'((PRIME_COUNT > 0) ? PRIME_COUNT - 1 : 0);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  typedef enum logic {PRIME, RUN} state_t;

  state_t               state, state_nxt;
  logic [PCW-1:0]       prime_cnt, prime_cnt_nxt;
  logic [LATENCY-1:0]   vld_p;
  logic                 tail_valid, push_req, push, pop;
  logic [ENTRY_W-1:0]   mem [DEPTH];
  logic [ENTRY_W-1:0]   entry, head;
  logic [ADDR_W-1:0]    wr_ptr, rd_ptr;

`ifdef FIR_CAP_NAN_FLAG_EN
  function automatic logic is_nan(input logic [BITS-1:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction
`endif

  // Stage: valid shadow of the FIR pipeline; tail lines up with fir_out
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= in_valid;
      for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  assign tail_valid = vld_p[LATENCY-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      if (PRIME_COUNT == 0) state <= RUN;
      else                  state <= PRIME;
      prime_cnt <= '0;
    end else begin
      state     <= state_nxt;
      prime_cnt <= prime_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    prime_cnt_nxt = prime_cnt;
    push_req      = 1'b0;
    case (state)
      PRIME: begin
        if (tail_valid) begin
          prime_cnt_nxt = prime_cnt + PCW'(1);
          if (prime_cnt == PRIME_LAST) state_nxt = RUN;
        end
      end
      RUN:     push_req = tail_valid;
      default: state_nxt = PRIME;
    endcase
  end

  assign primed = (state == RUN);

  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign pop  = out_valid && out_ready;
  assign push = push_req && ((count != FULL_CNT) || pop);

`ifdef FIR_CAP_NAN_FLAG_EN
  assign entry = {is_nan(fir_out), fir_out};
`else
  assign entry = fir_out;
`endif

  // Stage: FIFO control
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: ;
      endcase
      if (push_req && !push) overflow <= 1'b1;
    end
  end

  // Stage: FIFO storage, not reset; emptiness is tracked by the control state
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= entry;
  end

  assign head      = mem[rd_ptr];
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? head[BITS-1:0] : '0;

`ifdef FIR_CAP_NAN_FLAG_EN
  assign out_nan = out_valid && head[BITS];

  always_ff @(posedge clock) begin
    if (reset)                         nan_seen <= 1'b0;
    else if (push && is_nan(fir_out))  nan_seen <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_fir_out_capture.sv
// Directed bench for fir_out_capture: priming, backpressure/overflow, full push+pop,
// gapped input, mid-stream reset and (with FIR_CAP_NAN_FLAG_EN) NaN tagging.
module tb_fir_out_capture;
  localparam int BITS = 32, LATENCY = 20, PRIME_COUNT = 18, DEPTH = 8, ADDR_W = 3;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic [BITS-1:0]   fir_out = '0;
  logic              out_ready = 1'b0;
  logic [BITS-1:0]   out_data;
  logic              out_valid;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              primed;
`ifdef FIR_CAP_NAN_FLAG_EN
  logic              out_nan;
  logic              nan_seen;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  fir_out_capture #(
    .BITS(BITS), .LATENCY(LATENCY), .PRIME_COUNT(PRIME_COUNT), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .fir_out(fir_out),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count(count),
    .overflow(overflow),
    .primed(primed)
`ifdef FIR_CAP_NAN_FLAG_EN
    ,
    .out_nan(out_nan),
    .nan_seen(nan_seen)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; fir_out = '0;
    tick;
    reset = 1'b0;
  endtask

  initial begin
    // Priming with continuous input and an always-ready consumer
    do_reset;
    chk("rst out_valid", out_valid, 0);
    chk("rst count", count, 0);
    chk("rst overflow", overflow, 0);
    chk("rst primed", primed, 0);
    chk("rst out_data", out_data, 0);
    for (int t = 0; t < 45; t++) begin
      in_valid = 1'b1; out_ready = 1'b1; fir_out = 32'(t);
      if (t == 37) chk("prime primed_early", primed, 0);
      if (t == 38) begin
        chk("prime primed", primed, 1);
        chk("prime no_valid_yet", out_valid, 0);
      end
      if (t >= 39) begin
        chk("prime out_valid", out_valid, 1);
        chk("prime out_data", out_data, 64'(t - 1));
        chk("prime count", count, 1);
      end
      tick;
    end

    // Backpressure, fill, overflow, then drain in order
    do_reset;
    for (int t = 0; t < 57; t++) begin
      in_valid = (t <= 26); out_ready = (t >= 47); fir_out = 32'(100 + t);
      if (t == 40) begin
        chk("bp count2", count, 2);
        chk("bp head", out_data, 138);
      end
      if (t == 46) begin
        chk("bp full count", count, 8);
        chk("bp no_ovf_yet", overflow, 0);
        chk("bp head_stable", out_data, 138);
        chk("bp out_valid", out_valid, 1);
      end
      if (t == 47) begin
        chk("bp ovf count", count, 8);
        chk("bp overflow", overflow, 1);
      end
      if (t >= 47 && t <= 54) chk("bp drain", out_data, 64'(91 + t));
      if (t == 55) begin
        chk("bp empty count", count, 0);
        chk("bp empty valid", out_valid, 0);
        chk("bp empty data", out_data, 0);
        chk("bp ovf sticky", overflow, 1);
      end
      tick;
    end

    // Mid-stream reset while in RUN with overflow set and 5 entries queued
    for (int t = 0; t < 26; t++) begin
      in_valid = (t <= 4); out_ready = 1'b0; fir_out = 32'(400 + t);
      if (t == 25) begin
        chk("mr count5", count, 5);
        chk("mr head", out_data, 420);
        chk("mr primed_before", primed, 1);
        reset = 1'b1; in_valid = 1'b0;
      end
      tick;
    end
    reset = 1'b0;
    chk("mr count", count, 0);
    chk("mr out_valid", out_valid, 0);
    chk("mr overflow", overflow, 0);
    chk("mr primed", primed, 0);
    chk("mr out_data", out_data, 0);
    for (int t = 0; t < 41; t++) begin
      in_valid = 1'b1; out_ready = 1'b1; fir_out = 32'(500 + t);
      if (t == 38) chk("mr reprime empty", out_valid, 0);
      if (t == 39) begin
        chk("mr first valid", out_valid, 1);
        chk("mr first data", out_data, 538);
      end
      tick;
    end

    // Full FIFO with push and pop in the same cycle
    do_reset;
    for (int t = 0; t < 57; t++) begin
      in_valid = (t <= 26); out_ready = (t >= 46); fir_out = 32'(200 + t);
      if (t == 46) chk("pp full", count, 8);
      if (t == 47) begin
        chk("pp count", count, 8);
        chk("pp overflow", overflow, 0);
      end
      if (t >= 47 && t <= 54) chk("pp drain", out_data, 64'(192 + t));
      if (t == 55) begin
        chk("pp empty", count, 0);
        chk("pp ovf clear", overflow, 0);
      end
      tick;
    end

    // Gapped input 1,0,0,1,1 after the priming samples
    do_reset;
    for (int t = 0; t < 48; t++) begin
      in_valid = (t <= 18) || (t == 21) || (t == 22);
      out_ready = (t >= 43); fir_out = 32'(300 + t);
      if (t == 43) begin
        chk("gap count", count, 3);
        chk("gap d0", out_data, 338);
      end
      if (t == 44) chk("gap d1", out_data, 341);
      if (t == 45) chk("gap d2", out_data, 342);
      if (t == 46) begin
        chk("gap empty", count, 0);
        chk("gap valid", out_valid, 0);
      end
      tick;
    end

`ifdef FIR_CAP_NAN_FLAG_EN
    // NaN tagging; a NaN among the discarded results must not set nan_seen
    do_reset;
    for (int t = 0; t < 43; t++) begin
      in_valid = (t <= 19); out_ready = (t >= 40);
      fir_out = (t == 37 || t == 38) ? 32'h7FC00000 : (t == 39) ? 32'h7F800000 : 32'h3F800000;
      if (t == 38) chk("nan prime ignored", nan_seen, 0);
      if (t == 40) begin
        chk("nan count", count, 2);
        chk("nan data", out_data, 64'h7FC00000);
        chk("nan out_nan", out_nan, 1);
        chk("nan seen", nan_seen, 1);
      end
      if (t == 41) begin
        chk("inf data", out_data, 64'h7F800000);
        chk("inf out_nan", out_nan, 0);
      end
      tick;
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
